// File: rtl/ritc_dac_scheduler.sv
// Arbitrates user/servo writes into the 32-entry RITC DAC shadow, tracks dirty entries and
// sequences one-at-a-time serializer loads followed by a per-bank latch.
module ritc_dac_scheduler #(
    parameter logic [11:0] DEFAULT_VALUE    = 12'h800,
    parameter logic        SERVO_EN_DEFAULT = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        user_sel_i,
    input  logic        user_wr_i,
    input  logic        user_rd_i,
    input  logic [5:0]  user_addr_i,
    input  logic [31:0] user_dat_i,
    output logic [31:0] user_dat_o,
    input  logic [4:0]  servo_addr_i,
    input  logic        servo_wr_i,
    input  logic [11:0] servo_i,
    input  logic        servo_update_i,
    output logic        dac_req_o,
    output logic [4:0]  dac_addr_o,
    output logic [11:0] dac_dat_o,
    input  logic        dac_ack_i,
    output logic [1:0]  dac_latch_o,
    input  logic        dac_latch_ack_i,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {StIdle, StScan, StReq, StLatch, StDone} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [11:0] shadow_q [32];
    logic [31:0] dirty_q, dirty_d;
    logic [1:0]  loaded_q, loaded_d;
    logic        pending_q, pending_d;
    logic        servo_en_q, servo_en_d;
    logic [15:0] coll_q, coll_d;
    logic        rewrite_q, rewrite_d;
    logic [4:0]  dac_addr_q, dac_addr_d;
    logic [11:0] dac_dat_q, dac_dat_d;
    logic [31:0] rd_dat_q, rd_mux;

    logic user_wr_en, user_ent_we, ctrl_we, servo_ok, servo_we, collision, trigger;
    logic hit_idx, hit_cur;
    logic unused_dat;

    assign unused_dat = ^user_dat_i[31:12];

    assign user_wr_en  = user_sel_i & user_wr_i;
    assign user_ent_we = user_wr_en & ~user_addr_i[5];
    assign ctrl_we     = user_wr_en & (user_addr_i == 6'h20);
    assign servo_ok    = servo_wr_i & servo_en_q;
    // The user side always wins a same-cycle write; the servo write is dropped.
    assign servo_we    = servo_ok & ~user_ent_we;
    assign collision   = servo_ok & user_ent_we;
    assign trigger     = (ctrl_we & user_dat_i[0]) | (servo_update_i & servo_en_q);

    assign hit_idx = (user_ent_we && (user_addr_i[4:0] == idx_q)) ||
                     (servo_we && (servo_addr_i == idx_q));
    assign hit_cur = (user_ent_we && (user_addr_i[4:0] == dac_addr_q)) ||
                     (servo_we && (servo_addr_i == dac_addr_q));

    always_comb begin
        servo_en_d = ctrl_we ? user_dat_i[1] : servo_en_q;
        coll_d     = coll_q;
        if (ctrl_we && user_dat_i[2]) begin
            coll_d = 16'h0000;
        end else if (collision && (coll_q != 16'hFFFF)) begin
            coll_d = coll_q + 16'd1;
        end
    end

    // Dirty clear on ack is applied before new writes so an ack-cycle write keeps the bit set.
    always_comb begin
        dirty_d = dirty_q;
        if ((state_q == StReq) && dac_ack_i && !rewrite_q) begin
            dirty_d[dac_addr_q] = 1'b0;
        end
        if (user_ent_we) begin
            dirty_d[user_addr_i[4:0]] = 1'b1;
        end
        if (servo_we) begin
            dirty_d[servo_addr_i] = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        loaded_d   = loaded_q;
        pending_d  = pending_q | (trigger & (state_q != StIdle));
        rewrite_d  = rewrite_q;
        dac_addr_d = dac_addr_q;
        dac_dat_d  = dac_dat_q;
        unique case (state_q)
            StIdle: begin
                if (trigger || pending_q) begin
                    state_d   = StScan;
                    idx_d     = 5'd0;
                    pending_d = 1'b0;
                end
            end
            StScan: begin
                if (dirty_q[idx_q]) begin
                    state_d    = StReq;
                    dac_addr_d = idx_q;
                    dac_dat_d  = shadow_q[idx_q];
                    rewrite_d  = hit_idx;
                end else if (idx_q == 5'd31) begin
                    state_d = (loaded_q != 2'b00) ? StLatch : StDone;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            StReq: begin
                rewrite_d = rewrite_q | hit_cur;
                if (dac_ack_i) begin
                    loaded_d[dac_addr_q[4]] = 1'b1;
                    if (dac_addr_q == 5'd31) begin
                        state_d = StLatch;
                    end else begin
                        state_d = StScan;
                        idx_d   = dac_addr_q + 5'd1;
                    end
                end
            end
            StLatch: begin
                if (dac_latch_ack_i) begin
                    loaded_d = 2'b00;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (trigger || pending_q) begin
                    state_d   = StScan;
                    idx_d     = 5'd0;
                    pending_d = 1'b0;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rd_mux = 32'h0;
        if (!user_addr_i[5]) begin
            rd_mux = {20'h0, shadow_q[user_addr_i[4:0]]};
        end else if (user_addr_i == 6'h20) begin
            rd_mux = {coll_q, 12'h0, pending_q, busy_o, servo_en_q, |dirty_q};
        end else if (user_addr_i == 6'h21) begin
            rd_mux = dirty_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                shadow_q[i] <= DEFAULT_VALUE;
            end
        end else if (user_ent_we) begin
            shadow_q[user_addr_i[4:0]] <= user_dat_i[11:0];
        end else if (servo_we) begin
            shadow_q[servo_addr_i] <= servo_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            idx_q      <= 5'd0;
            dirty_q    <= 32'hFFFF_FFFF;
            loaded_q   <= 2'b00;
            pending_q  <= 1'b0;
            servo_en_q <= SERVO_EN_DEFAULT;
            coll_q     <= 16'h0000;
            rewrite_q  <= 1'b0;
            dac_addr_q <= 5'd0;
            dac_dat_q  <= 12'h000;
            rd_dat_q   <= 32'h0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            dirty_q    <= dirty_d;
            loaded_q   <= loaded_d;
            pending_q  <= pending_d;
            servo_en_q <= servo_en_d;
            coll_q     <= coll_d;
            rewrite_q  <= rewrite_d;
            dac_addr_q <= dac_addr_d;
            dac_dat_q  <= dac_dat_d;
            if (user_sel_i && user_rd_i) begin
                rd_dat_q <= rd_mux;
            end
        end
    end

    assign user_dat_o  = rd_dat_q;
    assign dac_req_o   = (state_q == StReq);
    assign dac_addr_o  = dac_addr_q;
    assign dac_dat_o   = dac_dat_q;
    assign dac_latch_o = (state_q == StLatch) ? loaded_q : 2'b00;
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);

endmodule

// File: tb/tb_ritc_dac_scheduler.sv
// Self-checking bench for ritc_dac_scheduler: directed scenarios plus randomized write traffic
// compared against an array-based model of the shadow, dirty set and collision counter.
module tb_ritc_dac_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        user_sel_i, user_wr_i, user_rd_i;
    logic [5:0]  user_addr_i;
    logic [31:0] user_dat_i, user_dat_o;
    logic [4:0]  servo_addr_i;
    logic        servo_wr_i;
    logic [11:0] servo_i;
    logic        servo_update_i;
    logic        dac_req_o;
    logic [4:0]  dac_addr_o;
    logic [11:0] dac_dat_o;
    logic        dac_ack_i;
    logic [1:0]  dac_latch_o;
    logic        dac_latch_ack_i;
    logic        busy_o, done_o;

    int total = 0;
    int bad   = 0;

    logic [11:0] shadow_m [32];
    logic [31:0] dirty_m;
    logic [15:0] coll_m;
    logic        servo_en_m;

    ritc_dac_scheduler dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .user_sel_i      (user_sel_i),
        .user_wr_i       (user_wr_i),
        .user_rd_i       (user_rd_i),
        .user_addr_i     (user_addr_i),
        .user_dat_i      (user_dat_i),
        .user_dat_o      (user_dat_o),
        .servo_addr_i    (servo_addr_i),
        .servo_wr_i      (servo_wr_i),
        .servo_i         (servo_i),
        .servo_update_i  (servo_update_i),
        .dac_req_o       (dac_req_o),
        .dac_addr_o      (dac_addr_o),
        .dac_dat_o       (dac_dat_o),
        .dac_ack_i       (dac_ack_i),
        .dac_latch_o     (dac_latch_o),
        .dac_latch_ack_i (dac_latch_ack_i),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) shadow_m[i] = 12'h800;
        dirty_m    = 32'hFFFF_FFFF;
        coll_m     = 16'h0;
        servo_en_m = 1'b1;
    endtask

    function automatic logic [31:0] exp_status_idle();
        return {coll_m, 12'h0, 1'b0, 1'b0, servo_en_m, |dirty_m};
    endfunction

    // One bus cycle with optional user write and servo activity, mirrored into the model.
    task automatic drive_cycle(input bit uw, input logic [5:0] ua, input logic [31:0] ud,
                               input bit sw, input logic [4:0] sa, input logic [11:0] sv,
                               input bit su);
        bit user_ent, servo_ok;
        user_sel_i = uw; user_wr_i = uw; user_addr_i = ua; user_dat_i = ud;
        servo_wr_i = sw; servo_addr_i = sa; servo_i = sv; servo_update_i = su;
        tick();
        user_sel_i = 0; user_wr_i = 0; user_addr_i = 0; user_dat_i = 0;
        servo_wr_i = 0; servo_addr_i = 0; servo_i = 0; servo_update_i = 0;
        user_ent = uw && (ua < 6'd32);
        servo_ok = sw && servo_en_m;
        if (user_ent) begin
            shadow_m[ua[4:0]] = ud[11:0];
            dirty_m[ua[4:0]]  = 1'b1;
        end
        if (servo_ok && user_ent) begin
            if (coll_m != 16'hFFFF) coll_m = coll_m + 16'd1;
        end else if (servo_ok) begin
            shadow_m[sa] = sv;
            dirty_m[sa]  = 1'b1;
        end
        if (uw && ua == 6'h20) begin
            servo_en_m = ud[1];
            if (ud[2]) coll_m = 16'h0;
        end
    endtask

    task automatic user_write(input logic [5:0] a, input logic [31:0] d);
        drive_cycle(1'b1, a, d, 1'b0, 5'd0, 12'h0, 1'b0);
    endtask

    task automatic user_read(input logic [5:0] a, output logic [31:0] d);
        user_sel_i = 1; user_rd_i = 1; user_addr_i = a;
        tick();
        user_sel_i = 0; user_rd_i = 0; user_addr_i = 0;
        d = user_dat_o;
    endtask

    // Services one load pass. Expected loads are every model-dirty entry in index order.
    task automatic run_pass(input int ack_wait, input bit rw_en, input logic [4:0] rw_addr,
                            input logic [11:0] rw_val, output int done_cyc);
        logic [4:0]  qa [$];
        logic [11:0] qd [$];
        logic [1:0]  exp_latch = 2'b00;
        logic [31:0] rd;
        int n = 0;
        int waitc = 0;
        bit got_done = 0, busy_all = 1, latch_seen = 0, rewrote = 0;
        for (int i = 0; i < 32; i++) begin
            if (dirty_m[i]) begin
                qa.push_back(5'(i));
                qd.push_back(shadow_m[i]);
                exp_latch[i / 16] = 1'b1;
            end
        end
        done_cyc = -1;
        for (int c = 0; c < 3000 && !got_done; c++) begin
            if (!busy_o) busy_all = 0;
            dac_latch_ack_i = 0;
            if (dac_req_o) begin
                if (waitc == 0) begin
                    if (n < qa.size()) begin
                        check("req_addr", 32'(dac_addr_o), 32'(qa[n]));
                        check("req_data", 32'(dac_dat_o), 32'(qd[n]));
                    end else begin
                        check("req_extra", n, qa.size());
                    end
                end
                if (rw_en && !rewrote && waitc == 1 && dac_addr_o == rw_addr && n < qa.size()) begin
                    dac_ack_i = 0;
                    user_write({1'b0, rw_addr}, {20'h0, rw_val});
                    check("hold_data", 32'(dac_dat_o), 32'(qd[n]));
                    check("hold_req", 32'(dac_req_o), 32'd1);
                    user_write(6'h20, 32'h3);
                    user_read(6'h20, rd);
                    check("pending_bit", 32'(rd[3]), 32'd1);
                    rewrote = 1;
                end
                if (waitc >= ack_wait) begin
                    dac_ack_i = 1;
                    if (!(rewrote && dac_addr_o == rw_addr)) dirty_m[dac_addr_o] = 1'b0;
                    n++;
                    waitc = 0;
                end else begin
                    dac_ack_i = 0;
                    waitc++;
                end
            end else begin
                dac_ack_i = 0;
            end
            if (dac_latch_o != 2'b00) begin
                if (!latch_seen) check("latch_mask", 32'(dac_latch_o), 32'(exp_latch));
                latch_seen = 1;
                dac_latch_ack_i = 1;
            end
            if (done_o) begin
                got_done = 1;
                done_cyc = c;
            end
            tick();
        end
        dac_ack_i = 0;
        dac_latch_ack_i = 0;
        check("pass_done", 32'(got_done), 32'd1);
        check("req_count", n, qa.size());
        check("latch_seen", 32'(latch_seen), 32'(exp_latch != 2'b00));
        check("busy_in_pass", 32'(busy_all), 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int cyc;
        bit latch_hit;

        rst_i = 1;
        user_sel_i = 0; user_wr_i = 0; user_rd_i = 0; user_addr_i = 0; user_dat_i = 0;
        servo_addr_i = 0; servo_wr_i = 0; servo_i = 0; servo_update_i = 0;
        dac_ack_i = 0; dac_latch_ack_i = 0;
        model_reset();
        #3;
        check("rst_outputs", {user_dat_o[15:0], 3'(dac_req_o), dac_addr_o, dac_latch_o,
                              busy_o, done_o}, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 0;
        tick();

        user_read(6'h20, rd);  check("rst_status", rd, exp_status_idle());
        user_read(6'h21, rd);  check("rst_dirty", rd, dirty_m);
        user_read(6'h0A, rd);  check("rst_entry", rd, {20'h0, shadow_m[10]});
        user_read(6'h22, rd);  check("unmapped_rd", rd, 32'h0);

        // Full pass after reset: all 32 entries load 0x800, both banks latch.
        user_write(6'h20, 32'h3);
        run_pass(0, 1'b0, 5'd0, 12'h0, cyc);
        user_read(6'h21, rd);  check("dirty_after_full", rd, 32'h0);

        // Clean pass: exact 33-cycle latency with nothing loaded.
        user_write(6'h20, 32'h3);
        run_pass(0, 1'b0, 5'd0, 12'h0, cyc);
        check("clean_done_cycle", cyc + 1, 33);

        // User write then servo-triggered pass.
        user_write(6'h13, 32'hFFFF_FABC);
        drive_cycle(1'b0, 6'h0, 32'h0, 1'b0, 5'd0, 12'h0, 1'b1);
        run_pass(1, 1'b0, 5'd0, 12'h0, cyc);

        // Same-cycle collision, then counter clear.
        drive_cycle(1'b1, 6'h05, 32'h111, 1'b1, 5'h05, 12'h222, 1'b0);
        user_read(6'h05, rd);  check("coll_entry", rd, 32'h111);
        user_read(6'h20, rd);  check("coll_status", rd, exp_status_idle());
        check("coll_count", 32'(rd[31:16]), 32'd1);
        user_write(6'h20, 32'h6);
        user_read(6'h20, rd);  check("coll_clear", rd, exp_status_idle());

        // Rewrite during a held REQ and a mid-pass GO that chains a second pass.
        user_write(6'h02, 32'h155);
        user_write(6'h20, 32'h3);
        run_pass(4, 1'b1, 5'h02, 12'h3FF, cyc);
        check("pending_autostart", 32'(busy_o), 32'd1);
        run_pass(0, 1'b0, 5'd0, 12'h0, cyc);
        user_read(6'h21, rd);  check("dirty_after_chain", rd, dirty_m);
        user_read(6'h02, rd);  check("entry2_final", rd, 32'h3FF);

        // Randomized write traffic followed by a checked pass.
        for (int round = 0; round < 3; round++) begin
            for (int k = 0; k < 24; k++) begin
                case ($urandom_range(0, 3))
                    0: user_write({1'b0, 5'($urandom)}, $urandom);
                    1: drive_cycle(1'b0, 6'h0, 32'h0, 1'b1, 5'($urandom), 12'($urandom), 1'b0);
                    2: drive_cycle(1'b1, {1'b0, 5'($urandom)}, $urandom, 1'b1, 5'($urandom),
                                   12'($urandom), 1'b0);
                    default: user_write(6'h20, 32'($urandom_range(0, 1)) << 1);
                endcase
            end
            user_read(6'h20, rd);  check("rnd_status", rd, exp_status_idle());
            user_read(6'h21, rd);  check("rnd_dirty", rd, dirty_m);
            user_write(6'h20, 32'h1 | (32'(servo_en_m) << 1));
            run_pass($urandom_range(0, 3), 1'b0, 5'd0, 12'h0, cyc);
            for (int j = 0; j < 4; j++) begin
                logic [4:0] a;
                a = 5'($urandom);
                user_read({1'b0, a}, rd);
                check("rnd_entry", rd, {20'h0, shadow_m[a]});
            end
        end

        // Reset while waiting in LATCH.
        user_write(6'h20, 32'h2);
        user_write(6'h1F, 32'h0AA);
        user_write(6'h20, 32'h3);
        latch_hit = 0;
        for (int c = 0; c < 200 && !latch_hit; c++) begin
            dac_ack_i = dac_req_o;
            if (dac_latch_o != 2'b00) latch_hit = 1;
            else tick();
        end
        dac_ack_i = 0;
        check("latch_reached", 32'(latch_hit), 32'd1);
        check("latch_before_rst", 32'(dac_latch_o), 32'h2);
        #2;
        rst_i = 1;
        #1;
        check("async_rst_outputs", {user_dat_o[15:0], 3'(dac_req_o), dac_addr_o, dac_latch_o,
                                    busy_o, done_o}, 32'h0);
        check("async_rst_dat", 32'(dac_dat_o), 32'h0);
        @(posedge clk_i); #1;
        rst_i = 0;
        model_reset();
        tick();
        for (int i = 0; i < 32; i++) begin
            user_read(6'(i), rd);
            check("post_rst_entry", rd, {20'h0, shadow_m[i]});
        end
        user_read(6'h21, rd);  check("post_rst_dirty", rd, 32'hFFFF_FFFF);
        user_read(6'h20, rd);  check("post_rst_status", rd, exp_status_idle());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ritc_dac_scheduler.md
Name: ritc_dac_scheduler

Overview:
Shared-access controller for the two RITC DAC banks. It arbitrates shadow-register writes from the GLITCBUS user side and the phase-scanner servo. It tracks which entries are dirty and sequences one-at-a-time loads into the downstream DAC serializer, followed by a per-bank latch. It sits between the GLITCBUS slave/phase scanner and the RITC DAC shifter, in the gb_clk domain.

Parameters:
DEFAULT_VALUE, 12'h800, reset value of every shadow entry.
SERVO_EN_DEFAULT, 1'b1, reset value of the servo-enable bit.

Ports:
clk_i  input  1  gb_clk; all logic on its rising edge.
rst_i  input  1  asynchronous, active-high reset.
user_sel_i  input  1  block selected on GLITCBUS.
user_wr_i  input  1  write strobe, qualified by user_sel_i.
user_rd_i  input  1  read strobe, qualified by user_sel_i.
user_addr_i  input  6  0x00-0x1F shadow entries (bit4 = bank); 0x20 control/status; 0x21 dirty mask.
user_dat_i  input  32  write data; bits [11:0] for entries.
user_dat_o  output  32  registered read data.
servo_addr_i  input  5  servo target entry (bit4 = bank).
servo_wr_i  input  1  servo shadow write strobe.
servo_i  input  12  servo value.
servo_update_i  input  1  servo load-pass request.
dac_req_o  output  1  load request to the serializer.
dac_addr_o  output  5  entry being loaded.
dac_dat_o  output  12  value being loaded.
dac_ack_i  input  1  serializer done with the current entry.
dac_latch_o  output  2  per-bank latch request.
dac_latch_ack_i  input  1  latch complete.
busy_o  output  1  load pass in progress.
done_o  output  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (async, any state):
  - Shadow entries = DEFAULT_VALUE; all 32 dirty bits set.
  - servo_en = SERVO_EN_DEFAULT; collision counter = 0; pending = 0; FSM = IDLE.
  - All outputs 0.
- Shadow writes:
  - A user write to 0x00-0x1F or a servo write (when servo_en = 1) updates the entry and sets its dirty bit, even if the value is unchanged.
  - A servo write while servo_en = 0 is ignored and is not counted.
  - User and servo write in the same cycle, either address: the user write wins, the servo write is dropped, and the 16-bit collision counter increments, saturating at 0xFFFF.
- Control write, 0x20:
  - bit0 GO: load-pass trigger.
  - bit1: servo_en.
  - bit2: clear the collision counter. If a collision occurs in the same cycle, clear wins.
- Reads:
  - user_dat_o is valid the cycle after user_rd_i & user_sel_i and holds until the next read.
  - Entry reads return {20'b0, value}.
  - 0x20 returns {collisions[15:0], 12'b0, pending, busy, servo_en, |dirty}.
  - 0x21 returns the dirty mask [31:0].
  - 0x22-0x3F return 0.
- Triggers: GO, or servo_update_i while servo_en = 1.
  - Trigger in IDLE: the pass starts on the next cycle.
  - Trigger while busy: sets pending (one deep; extra triggers are merged). A pending pass starts the cycle after done_o.
- FSM:
  - IDLE -> SCAN on trigger. busy_o = 1 from SCAN entry until the cycle after done_o.
  - SCAN: examines index 0..31, one per cycle.
    - Clean entry: advance to the next index.
    - Dirty entry: go to REQ; the value is captured into dac_dat_o/dac_addr_o.
  - REQ: dac_req_o = 1 and held, with stable address and data, until dac_ack_i. On ack: drop the request, clear the dirty bit, and set loaded[bank].
    - If the same entry was written during REQ or in the ack cycle, the dirty bit stays set; the new value goes out on the next pass.
    - Then return to SCAN at index+1.
  - After index 31 -> LATCH if loaded != 0, else DONE.
  - LATCH: dac_latch_o = loaded mask, held until dac_latch_ack_i; then clear loaded -> DONE.
  - DONE: done_o = 1 for one cycle -> IDLE.
- dac_ack_i and dac_latch_ack_i outside their wait states are ignored.
- Timing, clean pass: trigger write at cycle T; SCAN indices 0..31 at T+1..T+32; done_o at T+33.
- Servo and user writes are accepted in every state; the FSM never stalls writers.

Test Plan:
- Reset, then GO with ack tied high: 32 requests, addresses 0..31, all data 0x800; dac_latch_o = 2'b11; done_o pulses; 0x21 reads 0.
- GO with no dirty entries: no dac_req_o, no latch; done_o exactly 33 cycles after the GO write; busy_o high throughout.
- Write entry 0x13 = 0xABC, then servo_update_i: single request at address 0x13 with data 0xABC; dac_latch_o = 2'b10.
- Same-cycle user write 0x05 = 0x111 and servo write 0x05 = 0x222: entry reads 0x111; collision count = 1. Clear via bit2: count reads 0.
- Hold off ack on entry 0x02 and rewrite it to 0x3FF during REQ: dac_dat_o stays at the old value; after ack, the dirty bit is still set; a second GO loads 0x3FF. A GO issued mid-pass sets pending and the next pass auto-starts after done_o.
- Assert rst_i during LATCH: outputs drop to 0 asynchronously; afterwards all shadow entries read 0x800 and the dirty mask reads 0xFFFFFFFF.
